frac_sad_search: RTL and testbench
==================================

Name: frac_sad_search

Overview:
- Parametrised, pipelined successor of the combinational per-line fractional abs-diff stage.
- Accepts one line triple (upper/middle/lower reference lines) plus one original line per handshake.
- Forms the 25 quarter-pel candidates (rows UH,UQ,M,LQ,LH × columns h,q,f,r,i) and accumulates 25 SADs over LINES lines.
- Then scans for the minimum and returns the best candidate index and SAD to the motion-estimation controller.

Parameters:
- PIX_W, 8: pixel bit width.
- COLS, 6: inner columns compared per line; reference lines carry COLS+2 pixels.
- LINES, 6: lines per block.
- SAD_W, PIX_W+$clog2(COLS*LINES): accumulator and SAD output width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  line triple valid.
- in_ready  out  1  block can accept a line.
- cur_upper_pix  in  (COLS+2)*PIX_W  reference line above; pixel 0 at LSBs.
- cur_middle_pix  in  (COLS+2)*PIX_W  full-pel reference line.
- cur_lower_pix  in  (COLS+2)*PIX_W  reference line below.
- org_pix  in  COLS*PIX_W  original pixels aligned to reference pixels 1..COLS.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- best_idx  out  5  winning candidate, row*5+col; row UH=0..LH=4, col h=0,q=1,f=2,r=3,i=4; full pel = 12.
- best_sad  out  SAD_W  SAD of best_idx.

Behaviour:
- Interpolation arithmetic:
  - half = (a+b+1)>>1; quarter = (far+3*near+2)>>2.
  - Horizontal half/quarter use the existing filter_half/filter_quarter arithmetic widened to PIX_W.
  - Intermediates carry PIX_W+2 bits; results truncate to PIX_W.
  - abs diff is unsigned |org-cand|.
- Line transfer: occurs on in_valid && in_ready.
- Pipeline:
  - S1 registers the 25×COLS abs diffs.
  - S2 adds the per-candidate row sums into 25 accumulators.
  - Accumulators are cleared when the first line of a block is accepted (overwrite, not add).
- FSM states ACCUM, SEARCH, DONE; reset enters ACCUM.
- ACCUM:
  - in_ready=1; line_cnt counts accepted lines 0..LINES-1.
  - Accepting line LINES-1 at cycle T sets in_ready=0 from T+1.
  - Transition to SEARCH is taken at T+2, when the final accumulation lands.
- SEARCH:
  - Initial best = index 12 and its SAD.
  - Scans idx 0..24, one per cycle, replacing best only on strictly less SAD: ties keep 12, otherwise the lowest index.
  - After 25 cycles, enters DONE; out_valid rises at T+27.
- DONE:
  - best_idx and best_sad are held stable while out_valid && !out_ready.
  - On handshake: out_valid=0 next cycle, line_cnt=0, return to ACCUM, in_ready=1.
- Overflow: accumulators cannot overflow by SAD_W construction.
  - Verification must assert this for max inputs, e.g. all-255 versus all-0 → 36*255 = 9180 fits 14 bits.
- Reset, including mid-ACCUM or mid-SEARCH, gives next cycle:
  - out_valid=0, best_idx=12, best_sad=0, in_ready=1, line_cnt=0, pipeline valids=0.
  - Accumulators are cleared; in-flight lines are discarded.
- in_valid while in_ready=0 is ignored; the producer must hold its data.

Optional Feature:
- Macro FRAC_SAD_ALL_OUT_EN.
- When defined: adds output all_sad (25*SAD_W), with candidate k at bits [k*SAD_W +: SAD_W]. It is valid and held with out_valid, for rate-distortion cost addition downstream.
- When undefined: port absent; the accumulators are internal only, with no other behaviour change.

Decomposition:
- Shared package frac_sad_pkg holds:
  - candidate index constants (ROW_UH..ROW_LH, COL_H..COL_I, IDX_FULL=12, NUM_CAND=25);
  - FSM state enum;
  - function computing SAD_W.
- One sub-module, frac_cand_line: purely combinational, parametrised by PIX_W/COLS. It produces the 25×COLS candidate abs diffs for one line triple and is instantiated once ahead of S1.
- Adder trees and the min scan stay in the top.

Test Plan:
1. All inputs 100, LINES lines → out_valid at T+27; best_idx=12, best_sad=0.
2. upper=middle=lower=50, org=53 everywhere → all SADs 108, tie; best_idx=12, best_sad=108.
3. upper=0, middle=0, lower=200, org=100 → LH row SADs all 0, tie among 20..24; best_idx=20, best_sad=0. With FRAC_SAD_ALL_OUT_EN, all_sad[12]=3600.
4. Hold out_ready=0 for 10 cycles in DONE → best_idx/best_sad stable, in_ready=0, extra in_valid ignored. After handshake, the next block's accumulators start from 0.
5. Pulse rst_n=0 for one cycle at SEARCH cycle 10 → next cycle out_valid=0, in_ready=1, best_idx=12. The following block gives correct results.
6. in_valid toggling 1,0,1,… across a block → same result as back-to-back; max-value stress (org=255, refs=0) → best_sad=9180 without wrap.

Source files
------------

// File: rtl/frac_sad_pkg.sv
// ============================================================================
// Module      : frac_sad_pkg
// Description : Shared candidate indices, FSM state type and SAD width helper
//               for the quarter-pel SAD search.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package frac_sad_pkg;

    localparam int ROW_UH    = 0;
    localparam int ROW_UQ    = 1;
    localparam int ROW_M     = 2;
    localparam int ROW_LQ    = 3;
    localparam int ROW_LH    = 4;

    localparam int COL_H     = 0;
    localparam int COL_Q     = 1;
    localparam int COL_F     = 2;
    localparam int COL_R     = 3;
    localparam int COL_I     = 4;

    localparam int NUM_ROWS  = 5;
    localparam int NUM_HCOLS = 5;
    localparam int NUM_CAND  = 25;
    localparam int IDX_FULL  = 12;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic int calc_sad_w(input int pix_w, input int cols, input int lines);
        return pix_w + $clog2(cols * lines);
    endfunction

endpackage

`default_nettype wire

// File: rtl/frac_cand_line.sv
// ============================================================================
// Module      : frac_cand_line
// Description : Combinational 25-candidate quarter-pel interpolation and
//               absolute difference against the original line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frac_cand_line
    import frac_sad_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int COLS  = 6
) (
    input  logic [(COLS+2)*PIX_W-1:0]      cur_upper_pix,
    input  logic [(COLS+2)*PIX_W-1:0]      cur_middle_pix,
    input  logic [(COLS+2)*PIX_W-1:0]      cur_lower_pix,
    input  logic [COLS*PIX_W-1:0]          org_pix,
    output logic [NUM_CAND*COLS*PIX_W-1:0] cand_diff
);

    function automatic logic [PIX_W-1:0] f_half(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
        logic [PIX_W+1:0] w_sum;
        w_sum = {2'b00, a} + {2'b00, b} + {{(PIX_W+1){1'b0}}, 1'b1};
        return w_sum[PIX_W:1];
    endfunction

    function automatic logic [PIX_W-1:0] f_quarter(input logic [PIX_W-1:0] far_pix,
                                                    input logic [PIX_W-1:0] near_pix);
        logic [PIX_W+1:0] w_sum;
        w_sum = {2'b00, far_pix} + {2'b00, near_pix} + {1'b0, near_pix, 1'b0}
              + {{PIX_W{1'b0}}, 2'b10};
        return w_sum[PIX_W+1:2];
    endfunction

    function automatic logic [PIX_W-1:0] f_absdiff(input logic [PIX_W-1:0] a,
                                                    input logic [PIX_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Vertical interpolation first, over the full reference width
    logic [PIX_W-1:0] w_row [NUM_ROWS][COLS+2];

    generate
        for (genvar p = 0; p < COLS + 2; p++) begin : g_pix
            logic [PIX_W-1:0] w_u, w_m, w_l;
            assign w_u = cur_upper_pix[p*PIX_W +: PIX_W];
            assign w_m = cur_middle_pix[p*PIX_W +: PIX_W];
            assign w_l = cur_lower_pix[p*PIX_W +: PIX_W];
            assign w_row[ROW_UH][p] = f_half(w_u, w_m);
            assign w_row[ROW_UQ][p] = f_quarter(w_u, w_m);
            assign w_row[ROW_M][p]  = w_m;
            assign w_row[ROW_LQ][p] = f_quarter(w_l, w_m);
            assign w_row[ROW_LH][p] = f_half(w_l, w_m);
        end

        for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
            for (genvar j = 0; j < COLS; j++) begin : g_col
                logic [PIX_W-1:0] w_org, w_a, w_n, w_b;
                logic [PIX_W-1:0] w_cand [NUM_HCOLS];
                assign w_org = org_pix[j*PIX_W +: PIX_W];
                assign w_a   = w_row[r][j];
                assign w_n   = w_row[r][j+1];
                assign w_b   = w_row[r][j+2];
                assign w_cand[COL_H] = f_half(w_a, w_n);
                assign w_cand[COL_Q] = f_quarter(w_a, w_n);
                assign w_cand[COL_F] = w_n;
                assign w_cand[COL_R] = f_quarter(w_b, w_n);
                assign w_cand[COL_I] = f_half(w_b, w_n);
                for (genvar c = 0; c < NUM_HCOLS; c++) begin : g_diff
                    assign cand_diff[((r*NUM_HCOLS+c)*COLS+j)*PIX_W +: PIX_W] =
                        f_absdiff(w_org, w_cand[c]);
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/frac_sad_search.sv
// ============================================================================
// Module      : frac_sad_search
// Description : Pipelined 25-candidate quarter-pel SAD accumulation and
//               minimum search. FRAC_SAD_ALL_OUT_EN exposes all 25 SADs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frac_sad_search
    import frac_sad_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int COLS  = 6,
    parameter int LINES = 6,
    parameter int SAD_W = calc_sad_w(PIX_W, COLS, LINES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [(COLS+2)*PIX_W-1:0] cur_upper_pix,
    input  logic [(COLS+2)*PIX_W-1:0] cur_middle_pix,
    input  logic [(COLS+2)*PIX_W-1:0] cur_lower_pix,
    input  logic [COLS*PIX_W-1:0]     org_pix,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4:0]               best_idx,
`ifdef FRAC_SAD_ALL_OUT_EN
    output logic [NUM_CAND*SAD_W-1:0] all_sad,
`endif
    output logic [SAD_W-1:0]         best_sad
);

    localparam int LC_W = (LINES > 1) ? $clog2(LINES) : 1;

    logic [NUM_CAND*COLS*PIX_W-1:0] w_diff;
    logic                           w_accept;
    logic [SAD_W-1:0]               w_row_sum [NUM_CAND];

    state_t                         r_state;
    logic                           r_in_ready;
    logic                           r_out_valid;
    logic [LC_W-1:0]                r_line_cnt;
    logic                           r_s1_valid;
    logic                           r_s1_first;
    logic                           r_s1_last;
    logic                           r_s2_last;
    logic [NUM_CAND*COLS*PIX_W-1:0] r_s1_diff;
    logic [SAD_W-1:0]               r_acc [NUM_CAND];
    logic [4:0]                     r_scan_idx;
    logic [4:0]                     r_best_idx;
    logic [SAD_W-1:0]               r_best_sad;

    frac_cand_line #(
        .PIX_W (PIX_W),
        .COLS  (COLS)
    ) u_cand (
        .cur_upper_pix  (cur_upper_pix),
        .cur_middle_pix (cur_middle_pix),
        .cur_lower_pix  (cur_lower_pix),
        .org_pix        (org_pix),
        .cand_diff      (w_diff)
    );

    assign w_accept = in_valid && r_in_ready;

    always_comb begin
        for (int k = 0; k < NUM_CAND; k++) begin
            w_row_sum[k] = '0;
            for (int j = 0; j < COLS; j++) begin
                w_row_sum[k] = w_row_sum[k] + SAD_W'(r_s1_diff[(k*COLS+j)*PIX_W +: PIX_W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_line_cnt  <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s1_diff   <= '0;
            r_scan_idx  <= '0;
            r_best_idx  <= 5'(IDX_FULL);
            r_best_sad  <= '0;
            for (int k = 0; k < NUM_CAND; k++) r_acc[k] <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_diff  <= w_diff;
                r_s1_first <= (r_line_cnt == '0);
                r_s1_last  <= (r_line_cnt == LC_W'(LINES - 1));
            end
            r_s2_last <= r_s1_valid && r_s1_last;

            // First line of a block overwrites so no separate clear cycle is needed
            if (r_s1_valid) begin
                for (int k = 0; k < NUM_CAND; k++)
                    r_acc[k] <= r_s1_first ? w_row_sum[k] : r_acc[k] + w_row_sum[k];
            end

            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (r_line_cnt == LC_W'(LINES - 1)) begin
                            r_line_cnt <= '0;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_line_cnt <= r_line_cnt + 1'b1;
                        end
                    end
                    if (r_s2_last) begin
                        r_state    <= ST_SEARCH;
                        r_scan_idx <= '0;
                        r_best_idx <= 5'(IDX_FULL);
                        r_best_sad <= r_acc[IDX_FULL];
                    end
                end
                ST_SEARCH: begin
                    if (r_acc[r_scan_idx] < r_best_sad) begin
                        r_best_idx <= r_scan_idx;
                        r_best_sad <= r_acc[r_scan_idx];
                    end
                    if (r_scan_idx == 5'(NUM_CAND - 1)) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_ACCUM;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_line_cnt  <= '0;
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign best_idx  = r_best_idx;
    assign best_sad  = r_best_sad;

`ifdef FRAC_SAD_ALL_OUT_EN
    generate
        for (genvar k = 0; k < NUM_CAND; k++) begin : g_all_sad
            assign all_sad[k*SAD_W +: SAD_W] = r_acc[k];
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_frac_sad_search.sv
// ============================================================================
// Module      : tb_frac_sad_search
// Description : Randomised self-checking bench for frac_sad_search against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frac_sad_search;

    localparam int PIX_W = 8;
    localparam int COLS  = 6;
    localparam int LINES = 6;
    localparam int SAD_W = 14;
    localparam int RW    = COLS + 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic [RW*PIX_W-1:0]      cur_upper_pix;
    logic [RW*PIX_W-1:0]      cur_middle_pix;
    logic [RW*PIX_W-1:0]      cur_lower_pix;
    logic [COLS*PIX_W-1:0]    org_pix;
    logic                     out_valid;
    logic                     out_ready;
    logic [4:0]               best_idx;
    logic [SAD_W-1:0]         best_sad;
`ifdef FRAC_SAD_ALL_OUT_EN
    logic [25*SAD_W-1:0]      all_sad;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int ref_u [LINES][RW];
    int ref_m [LINES][RW];
    int ref_l [LINES][RW];
    int ref_o [LINES][COLS];
    int ref_sad [25];
    int exp_idx;
    int exp_sad;

    frac_sad_search #(
        .PIX_W (PIX_W),
        .COLS  (COLS),
        .LINES (LINES),
        .SAD_W (SAD_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .cur_upper_pix  (cur_upper_pix),
        .cur_middle_pix (cur_middle_pix),
        .cur_lower_pix  (cur_lower_pix),
        .org_pix        (org_pix),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .best_idx       (best_idx),
`ifdef FRAC_SAD_ALL_OUT_EN
        .all_sad        (all_sad),
`endif
        .best_sad       (best_sad)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Vertical row value: UH, UQ, M, LQ, LH
    function automatic int vrow(input int r, input int l, input int p);
        int u, m, d;
        u = ref_u[l][p];
        m = ref_m[l][p];
        d = ref_l[l][p];
        case (r)
            0:       return (u + m + 1) / 2;
            1:       return (u + 3 * m + 2) / 4;
            2:       return m;
            3:       return (d + 3 * m + 2) / 4;
            default: return (d + m + 1) / 2;
        endcase
    endfunction

    function automatic int hcand(input int r, input int c, input int l, input int j);
        int a, n, b;
        a = vrow(r, l, j);
        n = vrow(r, l, j + 1);
        b = vrow(r, l, j + 2);
        case (c)
            0:       return (a + n + 1) / 2;
            1:       return (a + 3 * n + 2) / 4;
            2:       return n;
            3:       return (b + 3 * n + 2) / 4;
            default: return (b + n + 1) / 2;
        endcase
    endfunction

    task automatic compute_ref();
        int d, mn;
        for (int k = 0; k < 25; k++) ref_sad[k] = 0;
        for (int l = 0; l < LINES; l++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    for (int j = 0; j < COLS; j++) begin
                        d = ref_o[l][j] - hcand(r, c, l, j);
                        ref_sad[r*5+c] += (d < 0) ? -d : d;
                    end
        mn = ref_sad[0];
        for (int k = 1; k < 25; k++) if (ref_sad[k] < mn) mn = ref_sad[k];
        exp_sad = mn;
        exp_idx = 12;
        if (ref_sad[12] != mn) begin
            for (int k = 24; k >= 0; k--) if (ref_sad[k] == mn) exp_idx = k;
        end
    endtask

    task automatic fill_const(input int u, input int m, input int d, input int o);
        for (int l = 0; l < LINES; l++) begin
            for (int p = 0; p < RW; p++) begin
                ref_u[l][p] = u;
                ref_m[l][p] = m;
                ref_l[l][p] = d;
            end
            for (int j = 0; j < COLS; j++) ref_o[l][j] = o;
        end
    endtask

    task automatic fill_rand(input int spread);
        int base;
        for (int l = 0; l < LINES; l++) begin
            for (int p = 0; p < RW; p++) begin
                base = $urandom_range(0, 255 - spread);
                ref_u[l][p] = base + $urandom_range(0, spread);
                ref_m[l][p] = base + $urandom_range(0, spread);
                ref_l[l][p] = base + $urandom_range(0, spread);
            end
            for (int j = 0; j < COLS; j++) ref_o[l][j] = $urandom_range(0, 255);
        end
    endtask

    task automatic load_line(input int l);
        for (int p = 0; p < RW; p++) begin
            cur_upper_pix[p*PIX_W +: PIX_W]  = PIX_W'(ref_u[l][p]);
            cur_middle_pix[p*PIX_W +: PIX_W] = PIX_W'(ref_m[l][p]);
            cur_lower_pix[p*PIX_W +: PIX_W]  = PIX_W'(ref_l[l][p]);
        end
        for (int j = 0; j < COLS; j++) org_pix[j*PIX_W +: PIX_W] = PIX_W'(ref_o[l][j]);
    endtask

    task automatic send_block(input bit gaps, output int t_last);
        bit done, rdy;
        int guard;
        t_last = 0;
        for (int l = 0; l < LINES; l++) begin
            load_line(l);
            in_valid = 1'b1;
            done  = 1'b0;
            guard = 0;
            while (!done) begin
                rdy = in_ready;
                step();
                if (rdy) begin
                    done   = 1'b1;
                    t_last = cyc;
                end else if (++guard > 50) begin
                    check("accept_timeout", 0, 1);
                    done = 1'b1;
                end
            end
            in_valid = 1'b0;
            if (gaps && l != LINES - 1) step();
        end
    endtask

    task automatic wait_result(input string tag, input int t_last);
        int guard;
        guard = 0;
        while (!out_valid && guard < 100) begin
            step();
            guard++;
        end
        check({tag, "_latency"}, cyc - t_last, 27);
        check({tag, "_idx"}, best_idx, exp_idx);
        check({tag, "_sad"}, best_sad, exp_sad);
`ifdef FRAC_SAD_ALL_OUT_EN
        for (int k = 0; k < 25; k++)
            check({tag, "_all_sad"}, all_sad[k*SAD_W +: SAD_W], ref_sad[k]);
`endif
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_hs_out_valid"}, out_valid, 0);
        check({tag, "_hs_in_ready"}, in_ready, 1);
    endtask

    task automatic run_block(input string tag, input bit gaps);
        int t_last;
        compute_ref();
        send_block(gaps, t_last);
        wait_result(tag, t_last);
        handshake(tag);
    endtask

    initial begin
        int t_last;
        logic [4:0]       held_idx;
        logic [SAD_W-1:0] held_sad;

        rst_n          = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        cur_upper_pix  = '0;
        cur_middle_pix = '0;
        cur_lower_pix  = '0;
        org_pix        = '0;
        step();
        step();
        rst_n = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_best_idx", best_idx, 12);
        check("rst_best_sad", best_sad, 0);

        fill_const(100, 100, 100, 100);
        run_block("flat100", 1'b0);

        fill_const(50, 50, 50, 53);
        run_block("tie108", 1'b0);

        fill_const(0, 0, 200, 100);
        run_block("lh_row", 1'b0);
        check("lh_row_ref_full", ref_sad[12], 3600);

        // Result held in DONE while consumer stalls; stray input ignored
        fill_rand(40);
        compute_ref();
        send_block(1'b0, t_last);
        wait_result("stall", t_last);
        held_idx = best_idx;
        held_sad = best_sad;
        for (int i = 0; i < 10; i++) begin
            in_valid       = 1'b1;
            cur_upper_pix  = {$urandom, $urandom};
            cur_middle_pix = {$urandom, $urandom};
            cur_lower_pix  = {$urandom, $urandom};
            org_pix        = {$urandom, $urandom};
            step();
            check("stall_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_idx", best_idx, held_idx);
            check("stall_sad", best_sad, held_sad);
        end
        in_valid = 1'b0;
        handshake("stall");
        fill_rand(20);
        run_block("after_stall", 1'b0);

        // Reset in the middle of the search
        fill_rand(30);
        send_block(1'b0, t_last);
        for (int i = 0; i < 12; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_best_idx", best_idx, 12);
        check("midrst_best_sad", best_sad, 0);
        fill_rand(50);
        run_block("after_rst", 1'b0);

        fill_rand(60);
        run_block("gapped", 1'b1);

        fill_const(0, 0, 0, 255);
        run_block("max_stress", 1'b1);
        check("max_stress_ref", exp_sad, 9180);

        for (int b = 0; b < 4; b++) begin
            fill_rand((b == 0) ? 255 : 16 * b);
            run_block("random", b[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
